// File: rtl/tri_raster_scheduler_if.sv
// Links around the raster scheduler: the set-up triangle descriptor coming in
// and the per-pixel request stream going out to the barycentric evaluator.

interface tri_desc_if #(
  parameter int SUBPIXEL_BITS  = 4,
  parameter int DENOM_INV_BITS = 36
);
  localparam int CW = 16 + SUBPIXEL_BITS;

  logic                      tri_valid;
  logic                      tri_ready;
  logic signed [15:0]        bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;
  logic signed [CW-1:0]      tri_v0x, tri_v0y, tri_e0x, tri_e0y, tri_e1x, tri_e1y;
  logic signed [DENOM_INV_BITS-1:0] tri_denom_inv;
  logic [11:0]               tri_v0_color, tri_v1_color, tri_v2_color;
  logic [31:0]               tri_v0_depth, tri_v1_depth, tri_v2_depth;

  modport master (
    output tri_valid, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
           tri_v0x, tri_v0y, tri_e0x, tri_e0y, tri_e1x, tri_e1y, tri_denom_inv,
           tri_v0_color, tri_v1_color, tri_v2_color,
           tri_v0_depth, tri_v1_depth, tri_v2_depth,
    input  tri_ready
  );

  modport slave (
    input  tri_valid, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
           tri_v0x, tri_v0y, tri_e0x, tri_e0y, tri_e1x, tri_e1y, tri_denom_inv,
           tri_v0_color, tri_v1_color, tri_v2_color,
           tri_v0_depth, tri_v1_depth, tri_v2_depth,
    output tri_ready
  );
endinterface

interface tri_pixel_if #(
  parameter int WIDTH          = 320,
  parameter int HEIGHT         = 240,
  parameter int SUBPIXEL_BITS  = 4,
  parameter int DENOM_INV_BITS = 36
);
  localparam int CW = 16 + SUBPIXEL_BITS;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic [XW-1:0]             pe_x;
  logic [YW-1:0]             pe_y;
  logic signed [CW-1:0]      pe_v0x, pe_v0y, pe_e0x, pe_e0y, pe_e1x, pe_e1y;
  logic signed [DENOM_INV_BITS-1:0] pe_denom_inv;
  logic [11:0]               pe_v0_color, pe_v1_color, pe_v2_color;
  logic [31:0]               pe_v0_depth, pe_v1_depth, pe_v2_depth;
  logic                      pe_valid;
  logic                      pe_ready;
  logic                      pe_busy;

  modport master (
    output pe_x, pe_y, pe_v0x, pe_v0y, pe_e0x, pe_e0y, pe_e1x, pe_e1y,
           pe_denom_inv, pe_v0_color, pe_v1_color, pe_v2_color,
           pe_v0_depth, pe_v1_depth, pe_v2_depth, pe_valid,
    input  pe_ready, pe_busy
  );

  modport slave (
    input  pe_x, pe_y, pe_v0x, pe_v0y, pe_e0x, pe_e0y, pe_e1x, pe_e1y,
           pe_denom_inv, pe_v0_color, pe_v1_color, pe_v2_color,
           pe_v0_depth, pe_v1_depth, pe_v2_depth, pe_valid,
    output pe_ready, pe_busy
  );
endinterface

// File: rtl/tri_raster_scheduler.sv
// Triangle sequencer: clamps the bounding box, walks it in raster order one
// pixel per cycle, waits for the evaluator to drain, then pulses done.

module tri_raster_scheduler #(
  parameter int  WIDTH          = 320,
  parameter int  HEIGHT         = 240,
  parameter int  SUBPIXEL_BITS  = 4,
  parameter int  DENOM_INV_BITS = 36,
  localparam int CNT_W          = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  tri_desc_if.slave        tri_in,
  tri_pixel_if.master      pe,
  output logic             done,
  output logic [CNT_W-1:0] pixel_count,
  output logic             busy
);

  localparam int CW = 16 + SUBPIXEL_BITS;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic signed [15:0] X_LAST = 16'(WIDTH - 1);
  localparam logic signed [15:0] Y_LAST = 16'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic signed [15:0] cx_min, cx_max, cy_min, cy_max;
  logic               box_empty, degenerate, accept, fire, last_x, last_y;

  logic [XW-1:0]    x_reg, xmin_reg, xmax_reg;
  logic [YW-1:0]    y_reg, ymax_reg;
  logic [CNT_W-1:0] count_reg, pixel_count_reg;
  logic             done_reg, drain_first_reg;

  logic signed [CW-1:0]             coord_in  [6];
  logic signed [CW-1:0]             coord_reg [6];
  logic [11:0]                      color_in  [3];
  logic [11:0]                      color_reg [3];
  logic [31:0]                      depth_in  [3];
  logic [31:0]                      depth_reg [3];
  logic signed [DENOM_INV_BITS-1:0] denom_reg;

  // Clamp against the screen with signed 16-bit compares.
  always_comb begin
    cx_min     = (tri_in.bbox_min_x < 16'sd0) ? 16'sd0 : tri_in.bbox_min_x;
    cx_max     = (tri_in.bbox_max_x > X_LAST) ? X_LAST : tri_in.bbox_max_x;
    cy_min     = (tri_in.bbox_min_y < 16'sd0) ? 16'sd0 : tri_in.bbox_min_y;
    cy_max     = (tri_in.bbox_max_y > Y_LAST) ? Y_LAST : tri_in.bbox_max_y;
    box_empty  = (cx_min > cx_max) || (cy_min > cy_max);
    degenerate = (tri_in.tri_denom_inv == '0);
  end

  // Only the low bits survive once the box is known to lie on screen.
  logic unused_clamp_bits;
  assign unused_clamp_bits = ^{cx_min[15:XW], cx_max[15:XW], cy_min[15:YW], cy_max[15:YW]};

  assign accept = tri_in.tri_valid && tri_in.tri_ready;
  assign fire   = pe.pe_valid && pe.pe_ready;
  assign last_x = (x_reg == xmax_reg);
  assign last_y = (y_reg == ymax_reg);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (accept) state_next = (box_empty || degenerate) ? FINISH : SCAN;
      SCAN:   if (fire && last_x && last_y) state_next = DRAIN;
      DRAIN:  if (!drain_first_reg && !pe.pe_busy) state_next = FINISH;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is registered, so tri_ready stays low through the done cycle.
  always_comb begin
    tri_in.tri_ready = 1'b0;
    pe.pe_valid      = 1'b0;
    busy             = 1'b1;
    case (state_reg)
      IDLE: begin
        tri_in.tri_ready = !done_reg;
        busy             = 1'b0;
      end
      SCAN:    pe.pe_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg           <= '0;
      y_reg           <= '0;
      xmin_reg        <= '0;
      xmax_reg        <= '0;
      ymax_reg        <= '0;
      count_reg       <= '0;
      pixel_count_reg <= '0;
      done_reg        <= 1'b0;
      drain_first_reg <= 1'b0;
    end else begin
      drain_first_reg <= (state_reg == SCAN) && (state_next == DRAIN);
      done_reg        <= (state_reg == FINISH);
      if (state_reg == FINISH) pixel_count_reg <= count_reg;
      if (accept) begin
        count_reg <= '0;
        if (!box_empty && !degenerate) begin
          x_reg    <= cx_min[XW-1:0];
          y_reg    <= cy_min[YW-1:0];
          xmin_reg <= cx_min[XW-1:0];
          xmax_reg <= cx_max[XW-1:0];
          ymax_reg <= cy_max[YW-1:0];
        end
      end else if (fire) begin
        count_reg <= count_reg + CNT_W'(1);
        if (!last_x) begin
          x_reg <= x_reg + XW'(1);
        end else if (!last_y) begin
          x_reg <= xmin_reg;
          y_reg <= y_reg + YW'(1);
        end
      end
    end
  end

  assign coord_in[0] = tri_in.tri_v0x;
  assign coord_in[1] = tri_in.tri_v0y;
  assign coord_in[2] = tri_in.tri_e0x;
  assign coord_in[3] = tri_in.tri_e0y;
  assign coord_in[4] = tri_in.tri_e1x;
  assign coord_in[5] = tri_in.tri_e1y;
  assign color_in[0] = tri_in.tri_v0_color;
  assign color_in[1] = tri_in.tri_v1_color;
  assign color_in[2] = tri_in.tri_v2_color;
  assign depth_in[0] = tri_in.tri_v0_depth;
  assign depth_in[1] = tri_in.tri_v1_depth;
  assign depth_in[2] = tri_in.tri_v2_depth;

  // Attributes are captured only at accept and held for the whole triangle.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_coord
      logic signed [CW-1:0] q;
      always_ff @(posedge clk) begin
        if (rst)         q <= '0;
        else if (accept) q <= coord_in[gi];
      end
      assign coord_reg[gi] = q;
    end
    for (gi = 0; gi < 3; gi++) begin : g_vertex
      logic [11:0] color_q;
      logic [31:0] depth_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          color_q <= '0;
          depth_q <= '0;
        end else if (accept) begin
          color_q <= color_in[gi];
          depth_q <= depth_in[gi];
        end
      end
      assign color_reg[gi] = color_q;
      assign depth_reg[gi] = depth_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)         denom_reg <= '0;
    else if (accept) denom_reg <= tri_in.tri_denom_inv;
  end

  assign pe.pe_x        = x_reg;
  assign pe.pe_y        = y_reg;
  assign pe.pe_v0x      = coord_reg[0];
  assign pe.pe_v0y      = coord_reg[1];
  assign pe.pe_e0x      = coord_reg[2];
  assign pe.pe_e0y      = coord_reg[3];
  assign pe.pe_e1x      = coord_reg[4];
  assign pe.pe_e1y      = coord_reg[5];
  assign pe.pe_denom_inv = denom_reg;
  assign pe.pe_v0_color = color_reg[0];
  assign pe.pe_v1_color = color_reg[1];
  assign pe.pe_v2_color = color_reg[2];
  assign pe.pe_v0_depth = depth_reg[0];
  assign pe.pe_v1_depth = depth_reg[1];
  assign pe.pe_v2_depth = depth_reg[2];

  assign done        = done_reg;
  assign pixel_count = pixel_count_reg;

endmodule

// File: tb/tb_tri_raster_scheduler.sv
// Bench for tri_raster_scheduler: a pixel-list model of each triangle is
// compared against the DUT every cycle, plus literal per-test expectations.

module tb_tri_raster_scheduler;
  localparam int WIDTH = 320;
  localparam int HEIGHT = 240;
  localparam int SB = 4;
  localparam int DB = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tri_desc_if  #(.SUBPIXEL_BITS(SB), .DENOM_INV_BITS(DB)) tri_in ();
  tri_pixel_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .SUBPIXEL_BITS(SB), .DENOM_INV_BITS(DB)) pe ();
  logic        done;
  logic [16:0] pixel_count;
  logic        busy;

  tri_raster_scheduler #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SUBPIXEL_BITS(SB), .DENOM_INV_BITS(DB)
  ) dut (
    .clk(clk), .rst(rst), .tri_in(tri_in), .pe(pe),
    .done(done), .pixel_count(pixel_count), .busy(busy)
  );

  // Evaluator stand-in: four-stage pipeline, busy while any stage holds a pixel.
  logic [3:0] ev_pipe;
  bit         ev_en = 1'b1;
  always @(posedge clk) begin
    if (rst) ev_pipe <= '0;
    else     ev_pipe <= {ev_pipe[2:0], pe.pe_valid && pe.pe_ready};
  end
  assign pe.pe_busy = ev_en && (|ev_pipe);

  int ready_mode = 0;
  int rdy_phase = 0;
  initial begin
    pe.pe_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        pe.pe_ready = 1'b1;
      end else begin
        pe.pe_ready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
    end
  end

  logic [287:0] attr_dut, attr_in;
  assign attr_dut = {pe.pe_v0x, pe.pe_v0y, pe.pe_e0x, pe.pe_e0y, pe.pe_e1x, pe.pe_e1y,
                     pe.pe_denom_inv, pe.pe_v0_color, pe.pe_v1_color, pe.pe_v2_color,
                     pe.pe_v0_depth, pe.pe_v1_depth, pe.pe_v2_depth};
  assign attr_in  = {tri_in.tri_v0x, tri_in.tri_v0y, tri_in.tri_e0x, tri_in.tri_e0y,
                     tri_in.tri_e1x, tri_in.tri_e1y, tri_in.tri_denom_inv,
                     tri_in.tri_v0_color, tri_in.tri_v1_color, tri_in.tri_v2_color,
                     tri_in.tri_v0_depth, tri_in.tri_v1_depth, tri_in.tri_v2_depth};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int x; int y; } pix_t;

  bit           model_on = 1'b0;
  pix_t         exp_q[$];
  pix_t         seen_q[$];
  int           seen_cyc[$];
  int           acc_cyc_q[$];
  int           done_cyc_q[$];
  logic [287:0] exp_attr = '0;
  bit           pending = 1'b0;
  bit           drain_track = 1'b0;
  int           drain_age = 0;
  int           done_due = -1;
  int           exp_count = 0;
  int           accepts = 0;
  int           obs_dones = 0;
  int           last_count = 0;

  // Expected pixel list of the triangle currently on the descriptor inputs.
  task automatic build_expect();
    int xmin, xmax, ymin, ymax;
    pix_t p;
    xmin = int'(tri_in.bbox_min_x);
    xmax = int'(tri_in.bbox_max_x);
    ymin = int'(tri_in.bbox_min_y);
    ymax = int'(tri_in.bbox_max_y);
    if (xmin < 0) xmin = 0;
    if (ymin < 0) ymin = 0;
    if (xmax > WIDTH - 1) xmax = WIDTH - 1;
    if (ymax > HEIGHT - 1) ymax = HEIGHT - 1;
    exp_q.delete();
    if (tri_in.tri_denom_inv != 0) begin
      for (int y = ymin; y <= ymax; y++) begin
        for (int x = xmin; x <= xmax; x++) begin
          p.x = x;
          p.y = y;
          exp_q.push_back(p);
        end
      end
    end
    exp_count = exp_q.size();
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      pix_t p;
      cyc++;
      chk("pe_valid", 288'(pe.pe_valid), 288'(exp_q.size() > 0));
      if (pe.pe_valid && exp_q.size() > 0) begin
        chk("pe_x", 288'(pe.pe_x), 288'(exp_q[0].x));
        chk("pe_y", 288'(pe.pe_y), 288'(exp_q[0].y));
      end
      chk("pe_attr", attr_dut, exp_attr);
      chk("tri_ready", 288'(tri_in.tri_ready), 288'(!pending));
      chk("done", 288'(done), 288'(pending && cyc == done_due));
      if (done) begin
        chk("pixel_count", 288'(pixel_count), 288'(exp_count));
        obs_dones++;
        last_count = int'(pixel_count);
        done_cyc_q.push_back(cyc);
      end
      if (!pending || done) chk("busy_idle", 288'(busy), 288'(0));
      else if (pe.pe_valid) chk("busy_scan", 288'(busy), 288'(1));

      if (rst) begin
        exp_q.delete();
        exp_attr    = '0;
        pending     = 1'b0;
        drain_track = 1'b0;
        done_due    = -1;
      end else begin
        if (pe.pe_valid && pe.pe_ready && exp_q.size() > 0) begin
          p = exp_q.pop_front();
          seen_q.push_back(p);
          seen_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            drain_track = 1'b1;
            drain_age   = 0;
          end
        end else if (drain_track) begin
          drain_age++;
          if (drain_age >= 2 && !pe.pe_busy) begin
            done_due    = cyc + 2;
            drain_track = 1'b0;
          end
        end
        if (tri_in.tri_valid && !pending) begin
          build_expect();
          exp_attr = attr_in;
          pending  = 1'b1;
          accepts++;
          acc_cyc_q.push_back(cyc);
          done_due = (exp_q.size() == 0) ? cyc + 2 : -1;
        end else if (pending && cyc == done_due) begin
          pending = 1'b0;
        end
      end
    end
  end

  task automatic set_tri(input int x0, input int x1, input int y0, input int y1,
                         input longint denom, input int seed);
    tri_in.bbox_min_x    = 16'(x0);
    tri_in.bbox_max_x    = 16'(x1);
    tri_in.bbox_min_y    = 16'(y0);
    tri_in.bbox_max_y    = 16'(y1);
    tri_in.tri_v0x       = 20'(seed * 16 + 1);
    tri_in.tri_v0y       = 20'(seed * 16 + 2);
    tri_in.tri_e0x       = 20'(-(seed * 8));
    tri_in.tri_e0y       = 20'(seed * 5 + 3);
    tri_in.tri_e1x       = 20'(seed * 7 + 4);
    tri_in.tri_e1y       = 20'(-(seed * 9));
    tri_in.tri_denom_inv = 36'(denom);
    tri_in.tri_v0_color  = 12'(seed * 100 + 1);
    tri_in.tri_v1_color  = 12'(seed * 100 + 2);
    tri_in.tri_v2_color  = 12'(seed * 100 + 3);
    tri_in.tri_v0_depth  = 32'((seed << 16) + 11);
    tri_in.tri_v1_depth  = 32'((seed << 16) + 22);
    tri_in.tri_v2_depth  = 32'((seed << 16) + 33);
  endtask

  task automatic wait_accepts(input int target);
    int i;
    for (i = 0; i < 400; i++) begin
      @(posedge clk);
      if (accepts >= target) break;
    end
    #1;
    if (i == 400) chk("accept_timeout", 288'(accepts), 288'(target));
  endtask

  task automatic wait_dones(input int target);
    int i;
    for (i = 0; i < 400; i++) begin
      if (obs_dones >= target) break;
      @(posedge clk);
    end
    #1;
    if (i == 400) chk("done_timeout", 288'(obs_dones), 288'(target));
  endtask

  task automatic clear_logs();
    seen_q.delete();
    seen_cyc.delete();
    acc_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic run_tri();
    int n_acc, n_done;
    n_acc  = accepts;
    n_done = obs_dones;
    tri_in.tri_valid = 1'b1;
    wait_accepts(n_acc + 1);
    tri_in.tri_valid = 1'b0;
    wait_dones(n_done + 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_pix(input string name, input int idx, input int x, input int y);
    if (idx < seen_q.size()) begin
      chk({name, "_x"}, 288'(seen_q[idx].x), 288'(x));
      chk({name, "_y"}, 288'(seen_q[idx].y), 288'(y));
    end else begin
      chk({name, "_missing"}, 288'(seen_q.size()), 288'(idx + 1));
    end
  endtask

  initial begin
    int n_done;
    tri_in.tri_valid = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 model_on = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_tri_ready", 288'(tri_in.tri_ready), 288'(1));
    chk("rst_pe_valid", 288'(pe.pe_valid), 288'(0));
    chk("rst_done", 288'(done), 288'(0));
    chk("rst_busy", 288'(busy), 288'(0));
    chk("rst_pixel_count", 288'(pixel_count), 288'(0));
    chk("rst_pe_xy", 288'({pe.pe_x, pe.pe_y}), 288'(0));
    chk("rst_attr", attr_dut, 288'(0));

    // 2x2 box, continuous ready, real evaluator drain
    clear_logs();
    set_tri(2, 3, 3, 4, 64'(1) << 30, 1);
    run_tri();
    chk_pix("t1_p0", 0, 2, 3);
    chk_pix("t1_p1", 1, 3, 3);
    chk_pix("t1_p2", 2, 2, 4);
    chk_pix("t1_p3", 3, 3, 4);
    chk("t1_count", 288'(last_count), 288'(4));
    if (seen_cyc.size() == 4 && acc_cyc_q.size() == 1 && done_cyc_q.size() == 1) begin
      chk("t1_first_cycle", 288'(seen_cyc[0] - acc_cyc_q[0]), 288'(1));
      chk("t1_back_to_back", 288'(seen_cyc[3] - seen_cyc[0]), 288'(3));
      chk("t1_done_latency", 288'(done_cyc_q[0] - acc_cyc_q[0]), 288'(11));
    end else begin
      chk("t1_log_sizes", 288'(seen_cyc.size()), 288'(4));
    end

    // same triangle with stalling ready
    clear_logs();
    ready_mode = 1;
    rdy_phase  = 0;
    run_tri();
    ready_mode = 0;
    chk("t2_seen", 288'(seen_q.size()), 288'(4));
    chk_pix("t2_p1", 1, 3, 3);
    chk_pix("t2_p3", 3, 3, 4);
    chk("t2_count", 288'(last_count), 288'(4));

    // box clipped on left and bottom; evaluator idle so drain is minimal
    clear_logs();
    ev_en = 1'b0;
    set_tri(-5, 2, 238, 300, 64'(1) << 30, 2);
    run_tri();
    ev_en = 1'b1;
    chk("t3_count", 288'(last_count), 288'(6));
    chk_pix("t3_first", 0, 0, 238);
    chk_pix("t3_last", 5, 2, 239);
    if (acc_cyc_q.size() == 1 && done_cyc_q.size() == 1)
      chk("t3_done_latency", 288'(done_cyc_q[0] - acc_cyc_q[0]), 288'(10));

    // degenerate triangle
    clear_logs();
    set_tri(2, 3, 3, 4, 0, 3);
    run_tri();
    chk("t4a_seen", 288'(seen_q.size()), 288'(0));
    chk("t4a_count", 288'(last_count), 288'(0));
    if (acc_cyc_q.size() == 1 && done_cyc_q.size() == 1)
      chk("t4a_done_latency", 288'(done_cyc_q[0] - acc_cyc_q[0]), 288'(2));

    // empty box
    clear_logs();
    set_tri(10, 9, 0, 5, 64'(1) << 30, 4);
    run_tri();
    chk("t4b_seen", 288'(seen_q.size()), 288'(0));
    chk("t4b_count", 288'(last_count), 288'(0));
    if (acc_cyc_q.size() == 1 && done_cyc_q.size() == 1)
      chk("t4b_done_latency", 288'(done_cyc_q[0] - acc_cyc_q[0]), 288'(2));

    // tri_valid held high while the next descriptor is already presented
    clear_logs();
    n_done = obs_dones;
    set_tri(0, 1, 0, 0, 64'(1) << 30, 5);
    tri_in.tri_valid = 1'b1;
    wait_accepts(accepts + 1);
    set_tri(5, 6, 7, 7, 64'(1) << 29, 9);
    wait_accepts(accepts + 1);
    tri_in.tri_valid = 1'b0;
    wait_dones(n_done + 2);
    chk("t5_seen", 288'(seen_q.size()), 288'(4));
    chk_pix("t5_a_last", 1, 1, 0);
    chk_pix("t5_b_first", 2, 5, 7);
    chk_pix("t5_b_last", 3, 6, 7);
    chk("t5_count", 288'(last_count), 288'(2));
    if (acc_cyc_q.size() == 2 && done_cyc_q.size() >= 1)
      chk("t5_second_accept", 288'(acc_cyc_q[1] - done_cyc_q[0]), 288'(1));

    // reset in the middle of a scan
    repeat (2) @(posedge clk);
    #1;
    n_done = obs_dones;
    set_tri(2, 5, 3, 3, 64'(1) << 30, 6);
    tri_in.tri_valid = 1'b1;
    wait_accepts(accepts + 1);
    tri_in.tri_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pe.pe_valid && pe.pe_x == 9'd3 && pe.pe_y == 8'd3) break;
      @(posedge clk);
      #1;
    end
    chk("t6_at_33", 288'({pe.pe_valid, pe.pe_x, pe.pe_y}), 288'({1'b1, 9'd3, 8'd3}));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_pe_valid", 288'(pe.pe_valid), 288'(0));
    chk("t6_tri_ready", 288'(tri_in.tri_ready), 288'(1));
    chk("t6_busy", 288'(busy), 288'(0));
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_done", 288'(obs_dones), 288'(n_done));

    // recovery after reset
    clear_logs();
    set_tri(0, 0, 0, 0, 64'(1) << 30, 7);
    run_tri();
    chk("t7_count", 288'(last_count), 288'(1));
    chk_pix("t7_p0", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tri_raster_scheduler.md
Name: tri_raster_scheduler

Overview:
- Triangle-level sequencer placed in front of the per-pixel barycentric evaluator in the renderer rasterizer.
- Accepts one set-up triangle per handshake: bounding box, v0, edge vectors, 1/denom, vertex colors and depths.
- Clamps the bounding box to the screen and walks it in raster order, issuing one pixel per cycle to the evaluator over a valid/ready link with the triangle attributes held stable.
- Waits for the evaluator pipeline to drain, then signals completion so the upstream setup stage can send the next triangle.

Parameters:
WIDTH, 320, screen width in pixels
HEIGHT, 240, screen height in pixels
SUBPIXEL_BITS, 4, fractional bits of vertex/edge coordinates
DENOM_INV_BITS, 36, width of signed 1/denom

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tri_valid  in  1  triangle descriptor valid
tri_ready  out  1  scheduler can accept a triangle
bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y  in  16 each, signed  inclusive integer-pixel bounding box
tri_v0x, tri_v0y, tri_e0x, tri_e0y, tri_e1x, tri_e1y  in  16+SUBPIXEL_BITS each, signed  v0 and edges
tri_denom_inv  in  DENOM_INV_BITS, signed  1/denom; 0 marks a degenerate triangle
tri_v0_color, tri_v1_color, tri_v2_color  in  12 each (color12_t)  vertex colors
tri_v0_depth, tri_v1_depth, tri_v2_depth  in  32 each (q16_16_t)  vertex depths
pe_x  out  $clog2(WIDTH)  pixel x to evaluator
pe_y  out  $clog2(HEIGHT)  pixel y to evaluator
pe_v0x … pe_v2_depth  out  same widths as tri_*  latched triangle attributes
pe_valid  out  1  pixel request valid
pe_ready  in  1  evaluator in_ready
pe_busy  in  1  evaluator busy
done  out  1  one-cycle pulse: triangle fully processed
pixel_count  out  $clog2(WIDTH*HEIGHT+1)  pixels issued for the last triangle; valid while done=1 and held until the next accept
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE. tri_ready=1. pe_valid=0, done=0, busy=0. pixel_count=0. pe_x/pe_y and all pe_* attributes=0.
- All state changes occur on rising clk; rst has priority over every event.
- States: IDLE, SCAN, DRAIN, FINISH.
- IDLE:
  - tri_ready=1.
  - On tri_valid: latch all tri_* into the pe_* registers, clear the pixel counter, and clamp the bbox:
    - xmin = max(bbox_min_x, 0); xmax = min(bbox_max_x, WIDTH-1)
    - ymin = max(bbox_min_y, 0); ymax = min(bbox_max_y, HEIGHT-1)
    - Comparisons are signed 16-bit.
  - Empty box (xmin>xmax or ymin>ymax) or tri_denom_inv==0: go to FINISH.
  - Otherwise: load pe_x=xmin, pe_y=ymin and go to SCAN.
- SCAN:
  - tri_ready=0, pe_valid=1. The first pe_valid is in the cycle after the accept edge.
  - On pe_valid&&pe_ready, increment the counter:
    - pe_x<xmax: pe_x+1.
    - pe_x==xmax and pe_y<ymax: pe_x=xmin, pe_y+1.
    - pe_x==xmax and pe_y==ymax: pe_valid drops and state goes to DRAIN.
  - With pe_ready=0, pe_x, pe_y and all attributes hold.
  - Throughput is 1 pixel/cycle under continuous ready.
- DRAIN:
  - pe_valid=0.
  - Stays here at least one cycle; pe_busy is not sampled in the entry cycle.
  - Leaves for FINISH at the first subsequent cycle with pe_busy==0.
- FINISH: done=1 for exactly one cycle, pixel_count updated, then IDLE. tri_ready returns to 1 in the cycle after done.
- pe_* attributes change only at a triangle accept.
- tri_valid outside IDLE is ignored; the triangle is not consumed.
- Counter width covers WIDTH*HEIGHT.
- Reset mid-SCAN or mid-DRAIN abandons the triangle: no done, pe_valid=0 the next cycle. Draining the evaluator is its own reset's job.

Test Plan:
- bbox x 2..3, y 3..4, denom_inv=1<<30, pe_ready=1, pe_busy driven by a real evaluator -> pe_(x,y) = (2,3),(3,3),(2,4),(3,4) on 4 consecutive cycles; done pulses once after pe_busy falls; pixel_count=4; tri_ready=1 next cycle.
- Same triangle, pe_ready toggling 1,0,0,1,… -> each coordinate held while ready=0; no coordinate skipped or repeated; pixel_count=4.
- bbox x -5..2, y 238..300 on 320x240 -> scan x 0..2, y 238..239; 6 pixels; last pixel (2,239).
- tri_denom_inv=0, or bbox_min_x=10 with bbox_max_x=9 -> pe_valid never asserts; done exactly 2 cycles after accept; pixel_count=0.
- tri_valid held high through a scan with changed attributes -> second triangle accepted only after done; pe_* unchanged during the first scan.
- rst asserted while pe_(x,y)=(3,3) mid-scan -> next cycle pe_valid=0, state IDLE, tri_ready=1, no done pulse.
